// File: rtl/item_dispenser.sv
// Vending slot controller: drives one slot motor, waits for the drop sensor,
// tracks per-slot stock. Optional single motor retry under `DISPENSE_RETRY_EN.
module item_dispenser #(
  parameter int NUM_ITEMS     = 4,
  parameter int MOTOR_CYCLES  = 8,
  parameter int SENSE_TIMEOUT = 64,
  parameter int STOCK_W       = 4,
  localparam int SEL_W        = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cfg_mode,
  input  logic                 dispense_enable,
  input  logic [SEL_W-1:0]     item_sel,
  input  logic                 stock_load,
  input  logic [STOCK_W-1:0]   stock_load_val,
  input  logic                 drop_sensor,
  output logic [NUM_ITEMS-1:0] motor_on,
  output logic                 dispense_valid,
  output logic                 dispense_fault,
  output logic [NUM_ITEMS-1:0] out_of_stock
);

  localparam int CNT_MAX = (MOTOR_CYCLES > SENSE_TIMEOUT) ? MOTOR_CYCLES : SENSE_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    MOTOR,
    SENSE,
    DONE,
    FAULT,
    WAIT_REL
  } state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [SEL_W-1:0]   slot, slot_next;
  logic               dec;
  logic [STOCK_W-1:0] stock [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] motor_next;
`ifdef DISPENSE_RETRY_EN
  logic               retry, retry_next;
`endif

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    slot_next  = slot;
    dec        = 1'b0;
`ifdef DISPENSE_RETRY_EN
    retry_next = retry;
`endif
    if (cfg_mode) begin
      next_state = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (dispense_enable) begin
            slot_next  = item_sel;
            cnt_next   = '0;
`ifdef DISPENSE_RETRY_EN
            retry_next = 1'b0;
`endif
            next_state = (stock[item_sel] == '0) ? FAULT : MOTOR;
          end
        end
        MOTOR: begin
          if (cnt == CNT_W'(MOTOR_CYCLES - 1)) begin
            next_state = SENSE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        SENSE: begin
          // Drop is checked before timeout so a drop on the last cycle still wins.
          if (drop_sensor) begin
            next_state = DONE;
            dec        = (stock[slot] != '0);
            cnt_next   = '0;
          end else if (cnt == CNT_W'(SENSE_TIMEOUT - 1)) begin
            cnt_next = '0;
`ifdef DISPENSE_RETRY_EN
            if (!retry) begin
              next_state = MOTOR;
              retry_next = 1'b1;
            end else begin
              next_state = FAULT;
            end
`else
            next_state = FAULT;
`endif
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        DONE:     next_state = WAIT_REL;
        WAIT_REL: if (!dispense_enable) next_state = IDLE;
        FAULT:    next_state = FAULT;
        default:  next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    motor_next = '0;
    if (next_state == MOTOR) motor_next[slot_next] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cnt            <= '0;
      slot           <= '0;
      motor_on       <= '0;
      dispense_valid <= 1'b0;
      dispense_fault <= 1'b0;
      out_of_stock   <= '1;
      stock          <= '{default: '0};
`ifdef DISPENSE_RETRY_EN
      retry          <= 1'b0;
`endif
    end else begin
      state          <= next_state;
      cnt            <= cnt_next;
      slot           <= slot_next;
      motor_on       <= motor_next;
      dispense_valid <= (next_state == DONE);
      dispense_fault <= (next_state == FAULT);
`ifdef DISPENSE_RETRY_EN
      retry          <= retry_next;
`endif
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        if (cfg_mode && stock_load && (item_sel == SEL_W'(i)))
          stock[i] <= stock_load_val;
        else if (dec && (slot == SEL_W'(i)))
          stock[i] <= stock[i] - STOCK_W'(1);
        // Flags follow the registered stock, so they trail a change by one cycle.
        out_of_stock[i] <= (stock[i] == '0);
      end
    end
  end

endmodule

// File: tb/tb_item_dispenser.sv
// Directed bench for item_dispenser: load, vend, empty fault, timeout,
// last-cycle drop, config abort, async reset and held request.
module tb_item_dispenser;
  logic       clk = 1'b0;
  logic       rstn;
  logic       cfg_mode, dispense_enable, stock_load, drop_sensor;
  logic [1:0] item_sel;
  logic [3:0] stock_load_val;
  logic [3:0] motor_on, out_of_stock;
  logic       dispense_valid, dispense_fault;
  int         total = 0;
  int         bad   = 0;

  item_dispenser #(
    .NUM_ITEMS(4), .MOTOR_CYCLES(8), .SENSE_TIMEOUT(64), .STOCK_W(4)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_mode(cfg_mode),
    .dispense_enable(dispense_enable), .item_sel(item_sel),
    .stock_load(stock_load), .stock_load_val(stock_load_val),
    .drop_sensor(drop_sensor), .motor_on(motor_on),
    .dispense_valid(dispense_valid), .dispense_fault(dispense_fault),
    .out_of_stock(out_of_stock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input logic [1:0] sel, input logic [3:0] val);
    cfg_mode = 1'b1; stock_load = 1'b1; item_sel = sel; stock_load_val = val;
    tick();
    cfg_mode = 1'b0; stock_load = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; cfg_mode = 1'b0; dispense_enable = 1'b0; stock_load = 1'b0;
    drop_sensor = 1'b0; item_sel = 2'd0; stock_load_val = 4'd0;
    ticks(2);
    chk("rst_motor", motor_on === 4'b0000);
    chk("rst_valid", dispense_valid === 1'b0);
    chk("rst_fault", dispense_fault === 1'b0);
    chk("rst_oos", out_of_stock === 4'b1111);
    rstn = 1'b1;
    tick();

    load(2'd2, 4'd3);
    tick();
    chk("load_stock2", dut.stock[2] === 4'd3);
    chk("load_oos", out_of_stock === 4'b1011);
    dispense_enable = 1'b1; item_sel = 2'd2;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("motor_slot2", motor_on === 4'b0100);
      tick();
    end
    chk("sense_motor_off", motor_on === 4'b0000);
    chk("sense_no_valid", dispense_valid === 1'b0);
    ticks(4);
    drop_sensor = 1'b1;
    tick();
    drop_sensor = 1'b0;
    chk("done_valid", dispense_valid === 1'b1);
    chk("done_stock2", dut.stock[2] === 4'd2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", dispense_valid === 1'b0);
      chk("hold_motor", motor_on === 4'b0000);
    end
    chk("hold_stock2", dut.stock[2] === 4'd2);
    dispense_enable = 1'b0;
    tick();

    dispense_enable = 1'b1; item_sel = 2'd1;
    tick();
    chk("empty_fault", dispense_fault === 1'b1);
    chk("empty_motor", motor_on === 4'b0000);
    ticks(3);
    chk("empty_fault_held", dispense_fault === 1'b1);
    chk("empty_no_valid", dispense_valid === 1'b0);
    dispense_enable = 1'b0; cfg_mode = 1'b1;
    tick();
    cfg_mode = 1'b0;
    chk("cfg_clears_fault", dispense_fault === 1'b0);

    load(2'd0, 4'd1);
    dispense_enable = 1'b1; item_sel = 2'd0;
    tick();
    ticks(8);
    ticks(63);
    chk("to_last_no_fault", dispense_fault === 1'b0);
    tick();
`ifdef DISPENSE_RETRY_EN
    chk("retry_motor", motor_on === 4'b0001);
    chk("retry_no_fault", dispense_fault === 1'b0);
    ticks(7);
    chk("retry_motor_end", motor_on === 4'b0001);
    tick();
    chk("retry_motor_off", motor_on === 4'b0000);
    ticks(63);
    chk("retry_last_no_fault", dispense_fault === 1'b0);
    tick();
`endif
    chk("to_fault", dispense_fault === 1'b1);
    chk("to_motor", motor_on === 4'b0000);
    chk("to_stock0", dut.stock[0] === 4'd1);
    chk("to_no_valid", dispense_valid === 1'b0);
    dispense_enable = 1'b0; cfg_mode = 1'b1;
    tick();
    cfg_mode = 1'b0;
    chk("to_cleared", dispense_fault === 1'b0);

    dispense_enable = 1'b1; item_sel = 2'd0;
    tick();
    ticks(8);
    ticks(63);
    chk("last_oos_before", out_of_stock === 4'b1010);
    drop_sensor = 1'b1;
    tick();
    drop_sensor = 1'b0;
    chk("last_valid", dispense_valid === 1'b1);
    chk("last_no_fault", dispense_fault === 1'b0);
    chk("last_stock0", dut.stock[0] === 4'd0);
    dispense_enable = 1'b0;
    ticks(2);
    chk("last_oos_after", out_of_stock === 4'b1011);

    dispense_enable = 1'b1; item_sel = 2'd2; drop_sensor = 1'b1;
    tick();
    tick();
    drop_sensor = 1'b0;
    tick();
    chk("abort_motor_c3", motor_on === 4'b0100);
    cfg_mode = 1'b1; dispense_enable = 1'b0;
    tick();
    cfg_mode = 1'b0;
    chk("abort_motor_off", motor_on === 4'b0000);
    chk("abort_no_valid", dispense_valid === 1'b0);
    chk("abort_stock2", dut.stock[2] === 4'd2);
    ticks(2);
    chk("abort_idle_motor", motor_on === 4'b0000);

    dispense_enable = 1'b1; item_sel = 2'd2;
    tick();
    ticks(8);
    ticks(2);
    rstn = 1'b0;
    #1;
    chk("mid_rst_motor", motor_on === 4'b0000);
    chk("mid_rst_valid", dispense_valid === 1'b0);
    chk("mid_rst_fault", dispense_fault === 1'b0);
    chk("mid_rst_oos", out_of_stock === 4'b1111);
    chk("mid_rst_stock2", dut.stock[2] === 4'd0);
    dispense_enable = 1'b0;
    tick();
    rstn = 1'b1;

    drop_sensor = 1'b1;
    ticks(3);
    drop_sensor = 1'b0;
    chk("idle_drop_valid", dispense_valid === 1'b0);
    chk("idle_drop_motor", motor_on === 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
